// File: rtl/matmul_operand_skew_pkg.sv
// Shared definitions for the matmul operand staging path: default geometry, element type
// and the skew controller state encoding.
package matmul_operand_skew_pkg;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultDim       = 4;

  typedef logic signed [DefaultDataWidth-1:0] elem_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDrain  = 2'd2
  } skew_state_t;

endpackage

// File: rtl/matmul_operand_skew_if.sv
// Slice-pair input handshake plus the skewed west/north edge streams feeding the array.
interface matmul_operand_skew_if
  import matmul_operand_skew_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DIM        = DefaultDim
);

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [DIM*DATA_WIDTH-1:0] a_row;
  logic [DIM*DATA_WIDTH-1:0] b_col;
  logic [DIM*DATA_WIDTH-1:0] a_west;
  logic [DIM*DATA_WIDTH-1:0] b_north;
  logic [DIM-1:0]            lane_valid;

  modport master (
    output in_valid, in_last, a_row, b_col,
    input  in_ready, a_west, b_north, lane_valid
  );

  modport slave (
    input  in_valid, in_last, a_row, b_col,
    output in_ready, a_west, b_north, lane_valid
  );

endinterface

// File: rtl/matmul_operand_skew_lane.sv
// One skew lane: a DEPTH-stage shift register of {valid, a, b}. Data entering with
// valid low is zeroed at the head so every stage holds zero whenever it is a bubble.
module matmul_operand_skew_lane
  import matmul_operand_skew_pkg::*;
#(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o
);

  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] a_q [DEPTH];
  logic [DATA_WIDTH-1:0] b_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      a_q[0]     <= valid_i ? a_i : '0;
      b_q[0]     <= valid_i ? b_i : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        a_q[i]     <= a_q[i-1];
        b_q[i]     <= b_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign a_o     = a_q[DEPTH-1];
  assign b_o     = b_q[DEPTH-1];

endmodule

// File: rtl/matmul_operand_skew.sv
// Operand staging ahead of the systolic array: lane i delays each accepted slice pair by
// i+1 cycles, then the controller drains the skew and pulses done_o.
module matmul_operand_skew
  import matmul_operand_skew_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DIM        = DefaultDim
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  matmul_operand_skew_if.slave  skew_if,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned CntW = $clog2(DIM);
  localparam logic [CntW-1:0] LoadCnt = CntW'(DIM - 1);

  skew_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready;
  logic            transfer;
  logic            done;
  logic [DIM-1:0]  lane_valid;

  assign ready    = !rst_i && (state_q != StDrain);
  assign transfer = skew_if.in_valid && ready;

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    matmul_operand_skew_lane #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (transfer),
      .a_i     (skew_if.a_row[i*DATA_WIDTH +: DATA_WIDTH]),
      .b_i     (skew_if.b_col[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid_o (lane_valid[i]),
      .a_o     (skew_if.a_west[i*DATA_WIDTH +: DATA_WIDTH]),
      .b_o     (skew_if.b_north[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // The counter hits zero exactly when the last slice reaches the deepest lane.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          if (skew_if.in_last) begin
            state_d = StDrain;
            cnt_d   = LoadCnt;
          end else begin
            state_d = StStream;
          end
        end
      end
      StStream: begin
        if (transfer && skew_if.in_last) begin
          state_d = StDrain;
          cnt_d   = LoadCnt;
        end
      end
      StDrain: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (lane_valid[DIM-1]) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign skew_if.in_ready   = ready;
  assign skew_if.lane_valid = lane_valid;
  assign busy_o             = (state_q != StIdle);
  assign done_o             = done && !rst_i;

endmodule
